// File: rtl/gen_rd_port_mux.sv
// gen_rd_port_mux: multi-port registered read mux over regs/pc/zero with writeback bypass,
// in-place refresh of stalled results and per-port illegal-select flags.
module gen_rd_port_mux #(
  parameter int                PA_DATA     = 32,
  parameter int                PA_SEL      = 9,
  parameter int                PA_NREG     = 16,
  parameter int                PA_NPORT    = 2,
  parameter logic [PA_SEL-1:0] PA_PC_SEL   = 9'h0FF,
  parameter logic [PA_SEL-1:0] PA_ZERO_SEL = 9'h100
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic [PA_NREG*PA_DATA-1:0]   regs,
  input  logic [PA_DATA-1:0]           pc,
  input  logic [PA_NPORT*PA_SEL-1:0]   sel,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         wb_en,
  input  logic [PA_SEL-1:0]            wb_sel,
  input  logic [PA_DATA-1:0]           wb_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PA_NPORT*PA_DATA-1:0]  out_data,
  output logic [PA_NPORT-1:0]          out_err
);
  logic                        accept, drain, valid_q, valid_d;
  logic [PA_NPORT*PA_DATA-1:0] data_q, data_d;
  logic [PA_NPORT-1:0]         err_q, err_d;
  logic [PA_NPORT*PA_SEL-1:0]  sel_q, sel_d;
  assign req_ready = !valid_q || out_ready;
  assign accept    = req_valid && req_ready;
  assign drain     = valid_q && out_ready;
  assign valid_d   = accept || (valid_q && !drain);
  for (genvar p = 0; p < PA_NPORT; p++) begin : g_port
    logic [PA_SEL-1:0]  s, cs;
    logic               is_reg, held_reg, dec_err;
    logic [PA_DATA-1:0] rd, dec;
    assign s        = sel[p*PA_SEL +: PA_SEL];
    assign cs       = sel_q[p*PA_SEL +: PA_SEL];
    assign is_reg   = int'(s) < PA_NREG;
    assign held_reg = int'(cs) < PA_NREG;
    always_comb begin
      rd = '0;
      for (int k = 0; k < PA_NREG; k++)
        if (int'(s) == k) rd = regs[k*PA_DATA +: PA_DATA];
    end
    // pc is never bypassed even when wb_sel carries the pc code
    assign dec     = is_reg ? ((wb_en && wb_sel == s) ? wb_data : rd) : (s == PA_PC_SEL) ? pc : '0;
    assign dec_err = !is_reg && s != PA_PC_SEL && s != PA_ZERO_SEL;
    assign data_d[p*PA_DATA +: PA_DATA] = accept ? dec :
      (valid_q && wb_en && held_reg && cs == wb_sel) ? wb_data : data_q[p*PA_DATA +: PA_DATA];
    assign err_d[p]                    = accept ? dec_err : err_q[p];
    assign sel_d[p*PA_SEL +: PA_SEL]   = accept ? s : cs;
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= '0;
      sel_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_err   = err_q;
endmodule

// File: tb/tb_gen_rd_port_mux.sv
// tb_gen_rd_port_mux: scoreboard bench; driver pushes expected results on accept,
// a negedge monitor compares held results, applies refresh to the model and pops on drain.
module tb_gen_rd_port_mux;
  logic         clk = 0, rst_b = 0;
  logic [511:0] regs;
  logic [31:0]  pc = 32'h0000_8000;
  logic [17:0]  sel = '0;
  logic         req_valid = 0, req_ready, wb_en = 0, out_valid, out_ready = 0;
  logic [8:0]   wb_sel = '0;
  logic [31:0]  wb_data = '0;
  logic [63:0]  out_data;
  logic [1:0]   out_err;
  int           total = 0, bad = 0;
  logic [63:0]  qd[$];
  logic [1:0]   qe[$];
  logic [17:0]  qs[$];

  gen_rd_port_mux dut (
    .clk(clk), .rst_b(rst_b), .regs(regs), .pc(pc), .sel(sel), .req_valid(req_valid),
    .req_ready(req_ready), .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // reference read of one port: {err, data}
  function automatic logic [32:0] model(input logic [8:0] s);
    if (s < 9'd16) return {1'b0, (wb_en && wb_sel == s) ? wb_data : regs[s*32 +: 32]};
    if (s == 9'h0FF) return {1'b0, pc};
    if (s == 9'h100) return 33'd0;
    return {1'b1, 32'd0};
  endfunction

  task automatic cycle(input logic rv, input logic [17:0] s, input logic orr,
                       input logic we, input logic [8:0] ws, input logic [31:0] wd,
                       input logic rr);
    logic [32:0] m0, m1;
    @(posedge clk); #1;
    if (rr) begin
      regs[$urandom_range(0, 15)*32 +: 32] = $urandom;
      pc = $urandom;
    end
    req_valid = rv; sel = s; out_ready = orr; wb_en = we; wb_sel = ws; wb_data = wd;
    #1;
    if (req_valid && req_ready) begin
      m0 = model(s[8:0]);
      m1 = model(s[17:9]);
      qd.push_back({m1[31:0], m0[31:0]});
      qe.push_back({m1[32], m0[32]});
      qs.push_back(s);
    end
  endtask

  always @(negedge clk) begin
    if (rst_b) begin
      if (out_valid) begin
        if (qd.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_valid actual=%h required=none", out_data);
        end else begin
          chk("data", out_data, qd[0]);
          chk("err", {62'd0, out_err}, {62'd0, qe[0]});
          if (out_ready) begin
            void'(qd.pop_front()); void'(qe.pop_front()); void'(qs.pop_front());
          end
        end
      end
      if (out_valid && !out_ready && !(req_valid && req_ready) && wb_en && qd.size() > 0) begin
        logic [63:0] t;
        t = qd[0];
        for (int p = 0; p < 2; p++)
          if (qs[0][p*9 +: 9] < 9'd16 && qs[0][p*9 +: 9] == wb_sel) t[p*32 +: 32] = wb_data;
        qd[0] = t;
      end
    end
  end

  function automatic logic [8:0] rsel();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return 9'($urandom_range(0, 15));
    if (r == 6) return 9'h0FF;
    if (r == 7) return 9'h100;
    return 9'($urandom);
  endfunction

  initial begin
    for (int k = 0; k < 16; k++) regs[k*32 +: 32] = $urandom;
    regs[3*32 +: 32]  = 32'hDEAD_0003;
    regs[15*32 +: 32] = 32'h0000_000F;
    regs[5*32 +: 32]  = 32'h0000_0011;
    #1;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", out_data, 64'd0);
    #11 rst_b = 1;
    cycle(1, {9'd15, 9'd3}, 1, 0, 9'd0, 32'd0, 0);
    cycle(1, {9'h100, 9'h0FF}, 1, 0, 9'd0, 32'd0, 0);
    cycle(1, {9'h0A5, 9'd0}, 1, 0, 9'd0, 32'd0, 0);
    cycle(1, {9'd0, 9'd5}, 1, 1, 9'd5, 32'h22, 0);
    cycle(1, {9'h0FF, 9'h0FF}, 1, 1, 9'h0FF, 32'h33, 0);
    cycle(1, {9'd5, 9'd5}, 1, 0, 9'd0, 32'd0, 0);
    cycle(1, {9'd1, 9'd2}, 0, 0, 9'd0, 32'd0, 0);
    chk("stall_rdy0", {63'd0, req_ready}, 64'd0);
    cycle(1, {9'd1, 9'd2}, 0, 1, 9'd5, 32'h77, 0);
    chk("stall_rdy1", {63'd0, req_ready}, 64'd0);
    cycle(1, {9'd1, 9'd2}, 0, 1, 9'd6, 32'h99, 0);
    chk("refresh_val", out_data, {32'h77, 32'h77});
    cycle(0, 18'd0, 1, 0, 9'd0, 32'd0, 0);
    for (int i = 0; i < 16; i++) begin
      cycle(1, {9'(15 - i), 9'(i)}, 1, 0, 9'd0, 32'd0, 0);
      if (i > 0) chk("b2b_valid", {63'd0, out_valid}, 64'd1);
    end
    cycle(0, 18'd0, 0, 0, 9'd0, 32'd0, 0);
    @(posedge clk); #3 rst_b = 0;
    #1;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    chk("mid_rst_err", {62'd0, out_err}, 64'd0);
    qd.delete(); qe.delete(); qs.delete();
    @(posedge clk); #2 rst_b = 1;
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, {rsel(), rsel()}, $urandom_range(0, 2) != 0,
            $urandom_range(0, 1) == 1, ($urandom_range(0, 7) == 0) ? 9'h0FF : 9'($urandom_range(0, 15)),
            $urandom, $urandom_range(0, 3) == 0);
    cycle(0, 18'd0, 1, 0, 9'd0, 32'd0, 0);
    cycle(0, 18'd0, 1, 0, 9'd0, 32'd0, 0);
    @(posedge clk); #1;
    chk("drained", {63'd0, out_valid}, 64'd0);
    chk("q_empty", 64'(qd.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gen_rd_port_mux.md
Name: gen_rd_port_mux

Overview:
- Parametrised, multi-port, registered register-file read mux for the core.
- Each of PA_NPORT read ports selects one of PA_NREG general registers, the PC, or constant zero.
- Results leave through a one-stage valid/ready output register.
- Adds same-cycle writeback bypass, in-place refresh of stalled results, and illegal-select flagging per port.

Parameters:
- PA_DATA, 32, data width in bits.
- PA_SEL, 9, select code width per port.
- PA_NREG, 16, number of general registers; codes 0..PA_NREG-1 select them.
- PA_NPORT, 2, number of independent read ports.
- PA_PC_SEL, 9'h0FF, select code returning pc.
- PA_ZERO_SEL, 9'h100, select code returning zero, no error.

Ports:
- clk  in  1  clock.
- rst_b  in  1  reset; asynchronous, active-low.
- regs  in  PA_NREG*PA_DATA  flattened register file; reg k at [k*PA_DATA +: PA_DATA].
- pc  in  PA_DATA  program counter value.
- sel  in  PA_NPORT*PA_SEL  flattened per-port select; port p at [p*PA_SEL +: PA_SEL].
- req_valid  in  1  request (all ports) present.
- req_ready  out  1  block can accept a request this cycle.
- wb_en  in  1  writeback strobe.
- wb_sel  in  PA_SEL  writeback target register code.
- wb_data  in  PA_DATA  writeback value.
- out_valid  out  1  out_data/out_err hold a result.
- out_ready  in  1  consumer takes the result.
- out_data  out  PA_NPORT*PA_DATA  flattened per-port result.
- out_err  out  PA_NPORT  per-port illegal-select flag.

Behaviour:
- Reset (async, rst_b=0):
  - out_valid=0, out_data=0, out_err=0, captured selects=0.
  - Any held result is discarded. Outputs stay at these values until the first accept after release.
- Handshake:
  - req_ready = !out_valid || out_ready (combinational).
  - Accept when req_valid && req_ready.
  - Drain when out_valid && out_ready.
  - Accept and drain in the same cycle is allowed: the new result replaces the old, out_valid stays 1, no bubble.
- Latency: a result appears on out_data with out_valid=1 in the cycle after accept.
- Stall: while out_valid && !out_ready, the block accepts nothing.
- Per-port decode, combinational from the current sel:
  - s < PA_NREG: regs[s]. If wb_en && wb_sel==s, wb_data instead (bypass).
  - s == PA_PC_SEL: pc. Never bypassed, even if wb_sel==PA_PC_SEL.
  - s == PA_ZERO_SEL: 0, err=0.
  - Any other code: data 0, err=1.
- Capture on accept: per-port decoded data, err, and the select code.
- Refresh while held:
  - Applies when out_valid=1, no accept this cycle, and wb_en=1.
  - Every port whose captured select is < PA_NREG and equals wb_sel loads wb_data at the clock edge.
  - PC, zero and error ports are never refreshed.
  - A drain with no accept still clears out_valid; refresh data is then irrelevant.
- Accept and refresh in the same cycle: the accept wins; the new capture already includes the bypass.
- When several ports select the same register, all of them bypass or refresh identically.
- No-accept, no-drain cycles: out_data and out_err hold, apart from refresh.
- All widths exact. Parameter legality (PA_NREG <= 2^PA_SEL, PA_PC_SEL and PA_ZERO_SEL >= PA_NREG and distinct) is the integrator's responsibility; it is not checked in RTL.

Test Plan:
- Reset → outputs: assert rst_b=0 mid-stream with out_valid=1 → out_valid, out_data and out_err are 0 immediately, before any clk edge.
- Basic read: regs[3]=0xDEAD0003, regs[15]=0x0000000F, sel={15,3}, req_valid=1, out_ready=1 → next cycle out_valid=1, port0=0xDEAD0003, port1=0x0000000F, out_err=00.
- Special codes:
  - sel port0=0x0FF, pc=0x00008000 → port0 = 0x00008000.
  - sel port1=0x100 → port1 = 0, err=0.
  - sel port1=0x0A5 → port1 = 0, out_err[1]=1.
- Bypass: regs[5]=0x11, wb_en=1, wb_sel=5, wb_data=0x22, sel port0=5 in the accept cycle → port0=0x22. With wb_sel=0x0FF and sel=0x0FF → pc is returned, not wb_data.
- Stall and refresh:
  - Capture sel={5,5}, then hold out_ready=0 for 3 cycles.
  - req_ready=0 during the stall; a new req_valid is ignored.
  - A wb to reg 5 with 0x77 → both ports read 0x77 next cycle.
  - A wb to reg 6 → no change.
- Back-to-back: out_ready=1 and req_valid=1 every cycle with sel incrementing 0..15 → 16 consecutive valid results, no bubbles, in order.
